prga_decrypt: RTL

- Downstream stage of the RC4 key-schedule (shuffle) stage.
- Once the shuffle reports `fin_strobe`, this block runs the RC4 pseudo-random generation algorithm (PRGA) over the shuffled S-array. It XORs each keystream byte with the encrypted-message ROM and writes plaintext to the decrypted-message RAM.
- It also keeps swapping entries in S, as RC4 requires.
- It shares the S-memory port with the shuffle stage; top-level muxing selects the active stage using `fsm_on`.

---
 rtl/prga_decrypt_if.sv | 29 ++
 rtl/prga_decrypt.sv | 137 +++++++++++++
 2 files changed

// File: rtl/prga_decrypt_if.sv
// Bus bundle between the RC4 PRGA stage and its memories/control.
// The slave side is the PRGA block itself; the master side is whoever owns
// the memories and the start control.
interface prga_decrypt_if;
  logic       start;
  logic [7:0] s_mem_out;
  logic [7:0] s_address;
  logic [7:0] s_mem_in;
  logic       s_wr_en;
  logic [7:0] enc_mem_out;
  logic [7:0] enc_address;
  logic [7:0] dec_address;
  logic [7:0] dec_mem_in;
  logic       dec_wr_en;
  logic       fsm_on;
  logic       fin_strobe;

  modport master (
    output start, s_mem_out, enc_mem_out,
    input  s_address, s_mem_in, s_wr_en, enc_address,
           dec_address, dec_mem_in, dec_wr_en, fsm_on, fin_strobe
  );

  modport slave (
    input  start, s_mem_out, enc_mem_out,
    output s_address, s_mem_in, s_wr_en, enc_address,
           dec_address, dec_mem_in, dec_wr_en, fsm_on, fin_strobe
  );
endinterface

// File: rtl/prga_decrypt.sv
// RC4 PRGA stage: walks the shuffled S-array, swaps S[i]/S[j], and XORs the
// keystream byte S[S[i]+S[j]] with the encrypted ROM into the plaintext RAM.
// Ten cycles per byte, all memory-side outputs registered (set on the edge
// that enters the state that uses them).
module prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  prga_decrypt_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, GET_SI, RD_SJ, GET_SJ,
    WR_I, WR_J, RD_F, GET_F, WR_D, DONE
  } state_t;

  // k is compared before it is incremented, so MSG_LEN=256 never overflows k
  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     r_state;
  logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_f;
  logic [7:0] r_s_address, r_s_mem_in, r_enc_address, r_dec_address;
  logic       r_s_wr_en, r_dec_wr_en, r_fsm_on, r_fin_strobe;

  logic [7:0] w_i_nxt, w_j_nxt, w_f_idx;

  assign w_i_nxt = r_i + 8'd1;
  assign w_j_nxt = r_j + bus.s_mem_out;
  assign w_f_idx = r_si + r_sj;

  assign bus.s_address   = r_s_address;
  assign bus.s_mem_in    = r_s_mem_in;
  assign bus.s_wr_en     = r_s_wr_en;
  assign bus.enc_address = r_enc_address;
  assign bus.dec_address = r_dec_address;
  assign bus.dec_wr_en   = r_dec_wr_en;
  assign bus.fsm_on      = r_fsm_on;
  assign bus.fin_strobe  = r_fin_strobe;
  // ROM address is held at k from RD_F through WR_D, so its data is stable here
  assign bus.dec_mem_in  = r_dec_wr_en ? (r_f ^ bus.enc_mem_out) : 8'h00;

  // Sequencer: state, RC4 indices and the registered memory-side outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_i           <= 8'h00;
      r_j           <= 8'h00;
      r_k           <= 8'h00;
      r_si          <= 8'h00;
      r_sj          <= 8'h00;
      r_f           <= 8'h00;
      r_s_address   <= 8'h00;
      r_s_mem_in    <= 8'h00;
      r_enc_address <= 8'h00;
      r_dec_address <= 8'h00;
      r_s_wr_en     <= 1'b0;
      r_dec_wr_en   <= 1'b0;
      r_fsm_on      <= 1'b0;
      r_fin_strobe  <= 1'b0;
    end else begin
      r_s_wr_en    <= 1'b0;
      r_dec_wr_en  <= 1'b0;
      r_fin_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_i      <= 8'h00;
            r_j      <= 8'h00;
            r_k      <= 8'h00;
            r_fsm_on <= 1'b1;
            r_state  <= INC_I;
          end
        end
        INC_I: begin
          r_i         <= w_i_nxt;
          r_s_address <= w_i_nxt;
          r_state     <= RD_SI;
        end
        RD_SI: r_state <= GET_SI;
        GET_SI: begin
          r_si        <= bus.s_mem_out;
          r_j         <= w_j_nxt;
          r_s_address <= w_j_nxt;
          r_state     <= RD_SJ;
        end
        RD_SJ: r_state <= GET_SJ;
        GET_SJ: begin
          // S[i] <= S[j]; the S[j] byte is still on the read port
          r_sj        <= bus.s_mem_out;
          r_s_address <= r_i;
          r_s_mem_in  <= bus.s_mem_out;
          r_s_wr_en   <= 1'b1;
          r_state     <= WR_I;
        end
        WR_I: begin
          // written second so that i==j leaves S[i] = si
          r_s_address <= r_j;
          r_s_mem_in  <= r_si;
          r_s_wr_en   <= 1'b1;
          r_state     <= WR_J;
        end
        WR_J: begin
          r_s_address   <= w_f_idx;
          r_s_mem_in    <= 8'h00;
          r_enc_address <= r_k;
          r_state       <= RD_F;
        end
        RD_F: r_state <= GET_F;
        GET_F: begin
          r_f           <= bus.s_mem_out;
          r_s_address   <= 8'h00;
          r_dec_address <= r_k;
          r_dec_wr_en   <= 1'b1;
          r_state       <= WR_D;
        end
        WR_D: begin
          r_enc_address <= 8'h00;
          r_dec_address <= 8'h00;
          if (r_k == LAST_K) begin
            r_fin_strobe <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= INC_I;
          end
        end
        DONE: begin
          r_fsm_on <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
